// File: rtl/s3g_tx_if.sv
// Request/buffer and UART transmit-side signals of the S3G response sequencer.
// The master modport is the requester/UART side; slave is the sequencer.
interface s3g_tx_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [7:0]        buf_wdata;
  logic              send;
  logic [7:0]        payload_len;
  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        frames_sent;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_done;

  modport master (
    output buf_we, buf_addr, buf_wdata, send, payload_len, tx_done,
    input  busy, done, err, frames_sent, tx_data, tx_wr
  );

  modport slave (
    input  buf_we, buf_addr, buf_wdata, send, payload_len, tx_done,
    output busy, done, err, frames_sent, tx_data, tx_wr
  );
endinterface

// File: rtl/s3g_tx.sv
// S3G response-packet sequencer: emits 0xD5, length, payload, CRC8 (Maxim, reflected)
// through the UART transmit handshake. Sole owner of the UART TX port.
module s3g_tx #(
  parameter int unsigned MAX_PAYLOAD = 32,
  parameter int unsigned ADDR_W      = 5
) (
  input  logic        clk,
  input  logic        rst,
  s3g_tx_if.slave     bus
);

  localparam int unsigned IDX_W    = ADDR_W + 1;
  localparam logic [7:0]  SOP_BYTE = 8'hD5;
  localparam logic [7:0]  MAX_LEN  = 8'(MAX_PAYLOAD);

  // Each byte has an issue state (tx_wr high) and a wait state (hold until tx_done).
  typedef enum logic [3:0] {
    S_IDLE, S_SOP_I, S_SOP_W, S_LEN_I, S_LEN_W, S_DATA_I, S_DATA_W, S_CRC_I, S_CRC_W
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       mem [MAX_PAYLOAD];
  logic [7:0]       len, len_nxt;
  logic [7:0]       crc, crc_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [7:0]       tx_data_q, tx_data_nxt;
  logic [7:0]       frames_q, frames_nxt;
  logic             tx_wr_q, tx_wr_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;
  logic [7:0]       rd_byte;

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    logic [7:0] b;
    r = c;
    b = d;
    for (int i = 0; i < 8; i++) begin
      if ((r[0] ^ b[0]) == 1'b1) r = (r >> 1) ^ 8'h8C;
      else                       r = r >> 1;
      b = b >> 1;
    end
    return r;
  endfunction

  // Payload buffer: frozen while a frame is in flight, never reset.
  always_ff @(posedge clk) begin
    if (bus.buf_we && !busy_q) mem[bus.buf_addr] <= bus.buf_wdata;
  end

  always_comb begin
    state_nxt   = state;
    len_nxt     = len;
    crc_nxt     = crc;
    idx_nxt     = idx;
    tx_data_nxt = tx_data_q;
    frames_nxt  = frames_q;
    tx_wr_nxt   = 1'b0;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    rd_byte     = mem[idx[ADDR_W-1:0]];
    unique case (state)
      S_IDLE: begin
        if (bus.send) begin
          if (bus.payload_len != 8'd0 && bus.payload_len <= MAX_LEN) begin
            len_nxt     = bus.payload_len;
            crc_nxt     = 8'h00;
            idx_nxt     = '0;
            busy_nxt    = 1'b1;
            tx_wr_nxt   = 1'b1;
            tx_data_nxt = SOP_BYTE;
            state_nxt   = S_SOP_I;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      S_SOP_I: state_nxt = S_SOP_W;
      S_SOP_W: begin
        if (bus.tx_done) begin
          tx_wr_nxt   = 1'b1;
          tx_data_nxt = len;
          state_nxt   = S_LEN_I;
        end
      end
      S_LEN_I: state_nxt = S_LEN_W;
      // len >= 1, so idx == len can only hold after at least one data byte.
      S_LEN_W, S_DATA_W: begin
        if (bus.tx_done) begin
          tx_wr_nxt = 1'b1;
          if (8'(idx) == len) begin
            tx_data_nxt = crc;
            state_nxt   = S_CRC_I;
          end else begin
            tx_data_nxt = rd_byte;
            crc_nxt     = crc8_step(crc, rd_byte);
            idx_nxt     = idx + IDX_W'(1);
            state_nxt   = S_DATA_I;
          end
        end
      end
      S_DATA_I: state_nxt = S_DATA_W;
      S_CRC_I:  state_nxt = S_CRC_W;
      S_CRC_W: begin
        if (bus.tx_done) begin
          busy_nxt   = 1'b0;
          done_nxt   = 1'b1;
          frames_nxt = frames_q + 8'd1;
          state_nxt  = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      len       <= 8'h00;
      crc       <= 8'h00;
      idx       <= '0;
      tx_data_q <= 8'h00;
      frames_q  <= 8'h00;
      tx_wr_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      len       <= len_nxt;
      crc       <= crc_nxt;
      idx       <= idx_nxt;
      tx_data_q <= tx_data_nxt;
      frames_q  <= frames_nxt;
      tx_wr_q   <= tx_wr_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      err_q     <= err_nxt;
    end
  end

  assign bus.tx_data     = tx_data_q;
  assign bus.tx_wr       = tx_wr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.frames_sent = frames_q;

endmodule

// File: tb/tb_s3g_tx.sv
// Directed bench for s3g_tx: a scripted UART responder returns tx_done and each
// emitted byte is compared against hand-computed frames.
module tb_s3g_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] exp_b [0:39];
  logic [7:0] exp_frames = 8'd0;

  s3g_tx_if #(.ADDR_W(5)) bus ();

  s3g_tx #(.MAX_PAYLOAD(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    bus.buf_we    = 1'b1;
    bus.buf_addr  = 5'(a);
    bus.buf_wdata = d;
    tick();
    bus.buf_we    = 1'b0;
  endtask

  task automatic do_send(input int l);
    bus.send        = 1'b1;
    bus.payload_len = 8'(l);
    tick();
    bus.send        = 1'b0;
  endtask

  // Starts in an issue cycle; returns one cycle after the last tx_done.
  task automatic xfer(input int n, input int gap, input bit spur, input bit poke);
    logic [7:0] d;
    bit ok;
    for (int i = 0; i < n; i++) begin
      chk("tx_wr_issue", 32'(bus.tx_wr), 32'd1);
      chk("tx_byte", 32'(bus.tx_data), 32'(exp_b[i]));
      d  = bus.tx_data;
      ok = 1'b1;
      for (int k = 0; k < gap; k++) begin
        if (k == 0 && spur) bus.tx_done = 1'b1;
        if (k == 0 && poke && i == 0) begin
          bus.send = 1'b1; bus.payload_len = 8'd5;
          bus.buf_we = 1'b1; bus.buf_addr = 5'd0; bus.buf_wdata = 8'hFF;
        end
        tick();
        bus.tx_done = 1'b0; bus.send = 1'b0; bus.buf_we = 1'b0;
        if (bus.tx_wr !== 1'b0 || bus.tx_data !== d || bus.busy !== 1'b1 ||
            bus.err !== 1'b0 || bus.done !== 1'b0) ok = 1'b0;
      end
      chk("wait_stable", 32'(ok), 32'd1);
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
    end
  endtask

  task automatic finish_frame();
    exp_frames = exp_frames + 8'd1;
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_clear", 32'(bus.busy), 32'd0);
    chk("frames_sent", 32'(bus.frames_sent), 32'(exp_frames));
  endtask

  task automatic set_len1();
    exp_b[0] = 8'hD5; exp_b[1] = 8'h01; exp_b[2] = 8'h01; exp_b[3] = 8'h5E;
  endtask

  task automatic set_digits();
    exp_b[0] = 8'hD5; exp_b[1] = 8'h09;
    for (int i = 0; i < 9; i++) exp_b[2+i] = 8'(8'h31 + i);
    exp_b[11] = 8'hA1;
  endtask

  initial begin
    bus.buf_we = 1'b0; bus.buf_addr = 5'd0; bus.buf_wdata = 8'h00;
    bus.send = 1'b0; bus.payload_len = 8'd0; bus.tx_done = 1'b0;

    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_tx_wr", 32'(bus.tx_wr), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
    chk("rst_frames", 32'(bus.frames_sent), 32'd0);
    rst = 1'b1;
    tick();

    // len=1, buffer written in the same cycle as send; first byte at send+1
    bus.buf_we = 1'b1; bus.buf_addr = 5'd0; bus.buf_wdata = 8'h01;
    bus.send = 1'b1; bus.payload_len = 8'd1;
    tick();
    bus.buf_we = 1'b0; bus.send = 1'b0;
    set_len1();
    xfer(4, 10, 1'b0, 1'b0);
    finish_frame();
    tick();
    chk("done_one_cycle", 32'(bus.done), 32'd0);

    // "123456789" -> CRC 0xA1
    for (int i = 0; i < 9; i++) wr(i, 8'(8'h31 + i));
    do_send(9);
    set_digits();
    xfer(12, 10, 1'b0, 1'b0);
    finish_frame();
    tick();

    // illegal lengths
    do_send(0);
    chk("err_len0", 32'(bus.err), 32'd1);
    chk("len0_no_wr", 32'(bus.tx_wr), 32'd0);
    chk("len0_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("err_one_cycle", 32'(bus.err), 32'd0);
    do_send(33);
    chk("err_len33", 32'(bus.err), 32'd1);
    chk("len33_no_wr", 32'(bus.tx_wr), 32'd0);
    chk("len33_busy", 32'(bus.busy), 32'd0);
    tick();

    // maximum length, all zeros
    for (int i = 0; i < 32; i++) wr(i, 8'h00);
    do_send(32);
    exp_b[0] = 8'hD5; exp_b[1] = 8'h20;
    for (int i = 0; i < 33; i++) exp_b[2+i] = 8'h00;
    xfer(35, 1, 1'b0, 1'b0);
    finish_frame();

    // send and buffer write during a frame are ignored
    wr(0, 8'h01);
    do_send(1);
    set_len1();
    xfer(4, 2, 1'b0, 1'b1);
    finish_frame();
    tick();
    do_send(1);
    xfer(4, 2, 1'b0, 1'b0);
    finish_frame();

    // spurious tx_done in IDLE and on every issue cycle
    bus.tx_done = 1'b1;
    tick(); tick();
    bus.tx_done = 1'b0;
    chk("idle_spur_busy", 32'(bus.busy), 32'd0);
    chk("idle_spur_wr", 32'(bus.tx_wr), 32'd0);
    do_send(1);
    xfer(4, 3, 1'b1, 1'b0);
    finish_frame();

    // back-to-back frames until frames_sent wraps
    for (int f = 0; f < 250; f++) begin
      do_send(1);
      xfer(4, 1, 1'b0, 1'b0);
      finish_frame();
    end
    chk("frames_wrap", 32'(bus.frames_sent), 32'd0);
    tick();

    // reset during the DATA wait phase
    for (int i = 0; i < 9; i++) wr(i, 8'(8'h31 + i));
    do_send(9);
    set_digits();
    xfer(3, 2, 1'b0, 1'b0);
    chk("mid_issue_data", 32'(bus.tx_data), 32'h32);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_frames = 8'd0;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_wr", 32'(bus.tx_wr), 32'd0);
    chk("mid_rst_frames", 32'(bus.frames_sent), 32'd0);
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    tick();
    chk("late_done_wr", 32'(bus.tx_wr), 32'd0);
    chk("late_done_busy", 32'(bus.busy), 32'd0);
    chk("late_done_done", 32'(bus.done), 32'd0);
    do_send(9);
    xfer(12, 3, 1'b0, 1'b0);
    finish_frame();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/s3g_tx.md
Name: s3g_tx

Overview:
- Response-packet sequencer for the host link.
- A requester fills an internal payload buffer, then pulses send.
- The block drives uart_transceiver's transmit side (tx_data/tx_wr/tx_done) to emit one S3G frame: 0xD5, length, payload, CRC8.
- Companion to s3g_rx. It replaces the direct rx->tx echo wiring at top level and is the single owner of the UART TX port.

Parameters:
- MAX_PAYLOAD, 32: payload buffer depth in bytes; legal payload_len range is 1..MAX_PAYLOAD.
- ADDR_W, 5: buffer address width; must equal clog2(MAX_PAYLOAD).

Ports:
- clk  in  1  system clock (osc_clk domain)
- rst  in  1  synchronous active-low reset
- buf_we  in  1  payload buffer write strobe
- buf_addr  in  ADDR_W  payload buffer write address
- buf_wdata  in  8  payload buffer write data
- send  in  1  one-cycle request to transmit a frame
- payload_len  in  8  payload byte count, sampled with send
- busy  out  1  high from accepted send until done
- done  out  1  one-cycle pulse when the CRC byte's tx_done is seen
- err  out  1  one-cycle pulse when send is rejected
- frames_sent  out  8  count of completed frames, wraps 255->0
- tx_data  out  8  byte to uart_transceiver
- tx_wr  out  1  one-cycle write strobe to uart_transceiver
- tx_done  in  1  one-cycle byte-complete pulse from uart_transceiver

Behaviour:
- All state updates on posedge clk. rst low (sync) forces:
  - state=IDLE; busy=0, done=0, err=0, tx_wr=0, tx_data=0x00, frames_sent=0.
  - The buffer contents are not cleared.
- Buffer: MAX_PAYLOAD x 8 register array.
  - Written when buf_we=1 and busy=0.
  - Writes while busy are ignored; the frame is frozen once accepted.
- send accept in IDLE:
  - Accepted if 1 <= payload_len <= MAX_PAYLOAD. On accept, latch len, clear crc to 0x00, set busy=1 next cycle.
  - Rejected otherwise: err=1 for one cycle, stay IDLE, no tx_wr.
  - send while busy is ignored (no err).
- Same cycle as send in IDLE: a buf_we write is committed and is visible in the frame.
- States: IDLE -> SOP -> LEN -> DATA -> CRC -> IDLE. Each byte state has an issue phase and a wait phase.
  - Issue: tx_wr=1 for exactly one cycle, with tx_data set in that same cycle.
  - Wait: tx_data held stable; tx_wr=0 until tx_done=1. The next byte is issued on the cycle after tx_done.
- Byte sequence:
  - SOP sends 0xD5.
  - LEN sends latched len.
  - DATA sends buf[0..len-1] in address order, using an index counter.
  - CRC sends the final crc.
- Latency: send accepted at cycle N -> tx_wr=1 with tx_data=0xD5 at cycle N+1.
- tx_done seen in IDLE or during an issue cycle is ignored.
- CRC8: Maxim/iButton reflected, poly 0x8C, init 0x00, over payload bytes only (not 0xD5 or len).
  - Per bit, LSB first: m=(crc^d)&1; crc>>=1; if m, crc^=0x8C; d>>=1.
  - crc is updated with each payload byte in the cycle that byte is issued.
- Completion: tx_done for the CRC byte -> next cycle done=1 (one cycle), busy=0, frames_sent+=1 (mod 256), state=IDLE.
  - A new send is accepted in the same cycle done is high.
- Reset mid-frame: abort immediately to IDLE; no further tx_wr is issued. A byte already handed to the UART completes on the line; its tx_done after reset is ignored.
- No timeout: a missing tx_done holds the block busy indefinitely (documented; the UART always completes).

Test Plan:
- buf[0]=0x01, send with len=1, tx_done returned 10 cycles after each tx_wr -> tx_wr bytes D5,01,01,5E; done one cycle after 4th tx_done; frames_sent=1; tx_wr at send+1.
- Buffer "123456789" (0x31..0x39), len=9 -> 12 tx_wr pulses: D5,09,31..39,A1; busy high throughout; tx_data stable during every wait.
- send with len=0, then with len=33 -> err pulse each time, no tx_wr, busy stays 0; then len=32 with all 0x00 -> CRC byte 0x00.
- During a frame: send and buf_we to addr 0 with 0xFF -> send ignored, buffer unchanged; next frame with len=1 still sends the original buf[0].
- Spurious tx_done in IDLE and during an issue cycle -> no state advance. Back-to-back: send in the done cycle -> second frame starts next cycle; 256 frames -> frames_sent wraps to 0.
- rst low during the DATA wait phase -> next cycle busy=0, tx_wr=0, frames_sent=0; a late tx_done is ignored; a following send transmits a full frame correctly.
